// File: rtl/rf_plus_alu_16bits.sv
// rf_plus_alu_16bits: 8x16 register file feeding a 16-bit ALU with operand muxes and registered flags
module rf_plus_alu_16bits (
  input  logic        clk,
  input  logic        clr,
  input  logic [15:0] wr_data,
  input  logic [15:0] pc,
  input  logic [7:0]  instr,
  input  logic [2:0]  wr_addr,
  input  logic [2:0]  rd_addr_a,
  input  logic [2:0]  rd_addr_b,
  input  logic [1:0]  alu_srcb,
  input  logic [1:0]  alu_ctrl,
  input  logic        wr_e,
  input  logic        e_flag,
  input  logic        alu_srca,
  output logic [15:0] rd_a,
  output logic [15:0] rd_b,
  output logic [15:0] alu_out,
  output logic [15:0] mem_wd,
  output logic        c,
  output logic        n,
  output logic        z,
  output logic        v
);
  logic [15:0] regs [8];
  logic [15:0] a, b, bx;
  logic [16:0] sum;
  logic        sub, arith, c_nx, v_nx;
  always_ff @(posedge clk)
    if (clr) regs <= '{default: '0};
    else if (wr_e) regs[wr_addr] <= wr_data;
  assign rd_a   = regs[rd_addr_a];
  assign rd_b   = regs[rd_addr_b];
  assign mem_wd = rd_b;
  assign a = alu_srca ? rd_a : pc;
  assign b = alu_srcb == 2'b00 ? rd_b :
             alu_srcb == 2'b01 ? 16'h0001 :
             alu_srcb == 2'b10 ? {{11{instr[4]}}, instr[4:0]} :
                                 {{8{instr[7]}}, instr[7:0]};
  assign arith = alu_ctrl[1];
  assign sub   = alu_ctrl == 2'b11;
  // subtraction is A + ~B + 1 so carry out means "no borrow"
  assign bx  = sub ? ~b : b;
  assign sum = {1'b0, a} + {1'b0, bx} + {16'b0, sub};
  always_comb begin
    alu_out = alu_ctrl == 2'b00 ? a & b :
              alu_ctrl == 2'b01 ? a | b : sum[15:0];
    c_nx = arith & sum[16];
    v_nx = arith & ((a[15] ^ b[15]) == sub) & (sum[15] != a[15]);
  end
  always_ff @(posedge clk)
    if (clr) {c, n, z, v} <= '0;
    else if (e_flag) {c, n, z, v} <= {c_nx, alu_out[15], alu_out == 16'h0, v_nx};
endmodule

// File: tb/tb_rf_plus_alu_16bits.sv
// tb_rf_plus_alu_16bits: directed vectors with hand-computed expectations for rf_plus_alu_16bits
module tb_rf_plus_alu_16bits;
  logic        clk = 0, clr = 0, wr_e = 0, e_flag = 0, alu_srca = 0;
  logic [15:0] wr_data = 0, pc = 0;
  logic [7:0]  instr = 0;
  logic [2:0]  wr_addr = 0, rd_addr_a = 0, rd_addr_b = 0;
  logic [1:0]  alu_srcb = 0, alu_ctrl = 0;
  logic [15:0] rd_a, rd_b, alu_out, mem_wd;
  logic        c, n, z, v;
  int total = 0, bad = 0;

  rf_plus_alu_16bits dut (
    .clk(clk), .clr(clr), .wr_data(wr_data), .pc(pc), .instr(instr),
    .wr_addr(wr_addr), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl), .wr_e(wr_e), .e_flag(e_flag),
    .alu_srca(alu_srca), .rd_a(rd_a), .rd_b(rd_b), .alu_out(alu_out),
    .mem_wd(mem_wd), .c(c), .n(n), .z(z), .v(v)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] adr, input logic [15:0] d);
    wr_e = 1; wr_addr = adr; wr_data = d;
    tick;
    wr_e = 0;
  endtask

  task automatic op(input logic sa, input logic [2:0] ra, input logic [2:0] rb,
                    input logic [1:0] sb, input logic [1:0] ct, input logic [7:0] ins);
    alu_srca = sa; rd_addr_a = ra; rd_addr_b = rb; alu_srcb = sb; alu_ctrl = ct; instr = ins;
    #1;
  endtask

  initial begin
    clr = 1; wr_e = 1; wr_addr = 3'd1; wr_data = 16'hBEEF;
    tick; tick;
    clr = 0; wr_e = 0;
    op(1, 1, 2, 2'b00, 2'b10, 8'h00);
    chk("rst_rd_a", rd_a, 16'h0);
    chk("rst_rd_b", rd_b, 16'h0);
    chk("rst_flags", {12'b0, c, n, z, v}, 16'h0);
    op(1, 0, 0, 2'b01, 2'b10, 8'h00);
    chk("rst_alu_follows_b", alu_out, 16'h0001);

    wr(3'd1, 16'h1234);
    wr(3'd2, 16'h1111);
    op(1, 1, 2, 2'b00, 2'b10, 8'h00);
    chk("add_rr", alu_out, 16'h2345);
    chk("mem_wd", mem_wd, 16'h1111);
    op(1, 1, 2, 2'b00, 2'b00, 8'h00);
    chk("and_rr", alu_out, 16'h1010);
    op(1, 1, 2, 2'b00, 2'b01, 8'h00);
    chk("or_rr", alu_out, 16'h1335);
    op(1, 2, 0, 2'b10, 2'b10, 8'h04);
    chk("add_imm5_pos", alu_out, 16'h1115);
    op(1, 2, 0, 2'b10, 2'b10, 8'h1F);
    chk("add_imm5_neg", alu_out, 16'h1110);
    pc = 16'h1000;
    op(0, 0, 0, 2'b01, 2'b10, 8'h00);
    chk("pc_plus1", alu_out, 16'h1001);
    op(1, 1, 0, 2'b11, 2'b10, 8'h34);
    chk("add_disp8_pos", alu_out, 16'h1268);
    op(1, 1, 0, 2'b11, 2'b10, 8'h80);
    chk("add_disp8_neg", alu_out, 16'h11B4);

    // no write-through: old value visible until the edge
    wr_e = 1; wr_addr = 3'd0; wr_data = 16'hA5A5;
    op(1, 0, 0, 2'b00, 2'b10, 8'h00);
    chk("no_bypass", rd_a, 16'h0000);
    tick;
    wr_e = 0;
    chk("r0_written", rd_a, 16'hA5A5);

    wr(3'd3, 16'h7FFF);
    op(1, 3, 0, 2'b01, 2'b10, 8'h00);
    e_flag = 1;
    chk("ovf_sum", alu_out, 16'h8000);
    tick;
    chk("flags_ovf", {12'b0, c, n, z, v}, 16'b0110_0000_0000_0101 & 16'h000F);
    op(1, 2, 2, 2'b00, 2'b11, 8'h00);
    chk("sub_zero", alu_out, 16'h0000);
    tick;
    chk("flags_sub_zero", {12'b0, c, n, z, v}, 16'b1010);
    op(1, 2, 1, 2'b00, 2'b11, 8'h00);
    chk("sub_borrow", alu_out, 16'hFEDD);
    tick;
    chk("flags_borrow", {12'b0, c, n, z, v}, 16'b0100);
    wr(3'd4, 16'hFFFF);
    op(1, 4, 0, 2'b01, 2'b10, 8'h00);
    chk("wrap_sum", alu_out, 16'h0000);
    tick;
    chk("flags_wrap", {12'b0, c, n, z, v}, 16'b1010);
    e_flag = 0;
    op(1, 1, 2, 2'b00, 2'b00, 8'h00);
    tick;
    chk("flags_hold", {12'b0, c, n, z, v}, 16'b1010);
    op(1, 1, 3, 2'b00, 2'b10, 8'h00);
    chk("add_before_clr", alu_out, 16'h9233);

    clr = 1; wr_e = 1; wr_addr = 3'd5; wr_data = 16'h5555; e_flag = 1;
    tick;
    clr = 0; wr_e = 0; e_flag = 0;
    op(1, 1, 5, 2'b00, 2'b10, 8'h00);
    chk("clr_r1", rd_a, 16'h0);
    chk("clr_wins_wr", rd_b, 16'h0);
    chk("clr_flags", {12'b0, c, n, z, v}, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
